// File: rtl/rf_issue_scoreboard.sv
// rf_issue_scoreboard
// Dual-issue register-file scoreboard that sits between ID and the issue stage.
// It keeps a small pending-write counter for each architectural GPR and decides
// each cycle whether lane 0 and/or lane 1 of the ID packet may issue. Writebacks
// from the two WB lanes retire those pending writes.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   flush_i            cancel every in-flight write; no issue this cycle
//   es_allowin_i       issue stage can take a packet
//   id0_* / id1_*      ID lane 0 (older) / lane 1 (younger): valid, sources
//                      rj/rk with read enables, destination rd with write enable
//   wb0_* / wb1_*      writeback lanes retiring a GPR write (valid, rd)
//   id0_fire_o         lane 0 issues
//   id1_fire_o         lane 1 issues (only ever together with lane 0)
//   id_stall_o         lane 0 valid but held back
//   rf_idle_o          registered: no pending writes anywhere
//   err_o              registered, sticky: a retire hit a zero counter
module rf_issue_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              es_allowin_i,
  input  logic              id0_valid_i,
  input  logic [ADDR_W-1:0] id0_rj_i,
  input  logic [ADDR_W-1:0] id0_rk_i,
  input  logic              id0_rj_re_i,
  input  logic              id0_rk_re_i,
  input  logic [ADDR_W-1:0] id0_rd_i,
  input  logic              id0_we_i,
  input  logic              id1_valid_i,
  input  logic [ADDR_W-1:0] id1_rj_i,
  input  logic [ADDR_W-1:0] id1_rk_i,
  input  logic              id1_rj_re_i,
  input  logic              id1_rk_re_i,
  input  logic [ADDR_W-1:0] id1_rd_i,
  input  logic              id1_we_i,
  input  logic              wb0_valid_i,
  input  logic [ADDR_W-1:0] wb0_rd_i,
  input  logic              wb1_valid_i,
  input  logic [ADDR_W-1:0] wb1_rd_i,
  output logic              id0_fire_o,
  output logic              id1_fire_o,
  output logic              id_stall_o,
  output logic              rf_idle_o,
  output logic              err_o
);

  // Counters are compared one bit wider so that "count + increments" never wraps.
  localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'((1 << CNT_W) - 1);

  logic [REG_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_NUM-1:0]            pend;
  logic [REG_NUM-1:0]            uf;
  logic                          err_q, err_d;
  logic                          idle_q, idle_d;

  logic            hz0, hz1, raw1, cap1, waw;
  logic [CNT_W:0]  cap1_sum;
  logic            fire0, fire1;

  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_pend
    assign pend[gi] = (cnt_q[gi] != '0);
  end

  // Lane 0: source RAW against in-flight writes, or destination counter saturated.
  assign hz0 = (id0_rj_re_i && pend[id0_rj_i]) ||
               (id0_rk_re_i && pend[id0_rk_i]) ||
               (id0_we_i && (id0_rd_i != '0) && ({1'b0, cnt_q[id0_rd_i]} == CNT_MAX));

  // Lane 1 reads the value lane 0 produces in the same packet: must wait.
  assign raw1 = id0_we_i && (id0_rd_i != '0) &&
                ((id1_rj_re_i && (id1_rj_i == id0_rd_i)) ||
                 (id1_rk_re_i && (id1_rk_i == id0_rd_i)));

  // Lane 1's own write, plus lane 0's write to the same register, must still
  // fit in the counter after the edge.
  assign waw      = id0_we_i && (id0_rd_i == id1_rd_i);
  assign cap1_sum = {1'b0, cnt_q[id1_rd_i]} + (CNT_W+1)'(waw) + (CNT_W+1)'(1);
  assign cap1     = id1_we_i && (id1_rd_i != '0) && (cap1_sum > CNT_MAX);

  assign hz1 = (id1_rj_re_i && pend[id1_rj_i]) ||
               (id1_rk_re_i && pend[id1_rk_i]) ||
               raw1 || cap1;

  assign fire0 = id0_valid_i && es_allowin_i && !flush_i && !hz0;
  assign fire1 = fire0 && id1_valid_i && !hz1;

  assign id0_fire_o = fire0;
  assign id1_fire_o = fire1;
  assign id_stall_o = id0_valid_i && !fire0;

  // r0 never tracks anything.
  assign cnt_d[0] = '0;
  assign uf[0]    = 1'b0;

  for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_cnt
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
    logic [1:0]     inc, dec;
    logic [CNT_W:0] sum;
    logic           under;

    assign inc = {1'b0, fire0 && id0_we_i && (id0_rd_i == IDX)} +
                 {1'b0, fire1 && id1_we_i && (id1_rd_i == IDX)};
    assign dec = {1'b0, wb0_valid_i && (wb0_rd_i == IDX)} +
                 {1'b0, wb1_valid_i && (wb1_rd_i == IDX)};
    assign sum   = {1'b0, cnt_q[gi]} + (CNT_W+1)'(inc);
    assign under = ((CNT_W+1)'(dec) > sum);

    // A flush wipes the counter and masks any same-cycle retire from the error.
    assign cnt_d[gi] = (flush_i || under) ? '0 : CNT_W'(sum - (CNT_W+1)'(dec));
    assign uf[gi]    = under && !flush_i;
  end

  assign err_d  = err_q || (|uf);
  assign idle_d = (cnt_d == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      err_q  <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      idle_q <= idle_d;
    end
  end

  assign rf_idle_o = idle_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_rf_issue_scoreboard.sv
// tb_rf_issue_scoreboard
// Directed table of packets from reset, a reset-clears-error sequence, then a
// randomized run checked against an integer-array model of the scoreboard rules.
module tb_rf_issue_scoreboard;

  localparam int CMAX = 3;
  localparam int NROW = 26;

  typedef struct {
    int v, rj, rjre, rk, rkre, rd, we;
  } lane_t;

  typedef struct {
    int    fl, al;
    lane_t l0, l1;
    int    w0v, w0, w1v, w1;
    int    ef0, ef1, est, eidle, eerr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_i, es_allowin_i;
  logic       id0_valid_i, id0_rj_re_i, id0_rk_re_i, id0_we_i;
  logic [4:0] id0_rj_i, id0_rk_i, id0_rd_i;
  logic       id1_valid_i, id1_rj_re_i, id1_rk_re_i, id1_we_i;
  logic [4:0] id1_rj_i, id1_rk_i, id1_rd_i;
  logic       wb0_valid_i, wb1_valid_i;
  logic [4:0] wb0_rd_i, wb1_rd_i;
  logic       id0_fire_o, id1_fire_o, id_stall_o, rf_idle_o, err_o;

  int    total = 0;
  int    bad   = 0;
  vec_t  tbl[NROW];
  lane_t nl;
  int    m_cnt[32];
  int    m_err, m_idle;

  always #5 clk = ~clk;

  rf_issue_scoreboard dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .es_allowin_i(es_allowin_i),
    .id0_valid_i(id0_valid_i), .id0_rj_i(id0_rj_i), .id0_rk_i(id0_rk_i),
    .id0_rj_re_i(id0_rj_re_i), .id0_rk_re_i(id0_rk_re_i),
    .id0_rd_i(id0_rd_i), .id0_we_i(id0_we_i),
    .id1_valid_i(id1_valid_i), .id1_rj_i(id1_rj_i), .id1_rk_i(id1_rk_i),
    .id1_rj_re_i(id1_rj_re_i), .id1_rk_re_i(id1_rk_re_i),
    .id1_rd_i(id1_rd_i), .id1_we_i(id1_we_i),
    .wb0_valid_i(wb0_valid_i), .wb0_rd_i(wb0_rd_i),
    .wb1_valid_i(wb1_valid_i), .wb1_rd_i(wb1_rd_i),
    .id0_fire_o(id0_fire_o), .id1_fire_o(id1_fire_o), .id_stall_o(id_stall_o),
    .rf_idle_o(rf_idle_o), .err_o(err_o)
  );

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic lane_t L(int v, int rj, int rjre, int rk, int rkre, int rd, int we);
    lane_t l;
    l.v = v; l.rj = rj; l.rjre = rjre; l.rk = rk; l.rkre = rkre; l.rd = rd; l.we = we;
    return l;
  endfunction

  task automatic drive(int fl, int al, lane_t a, lane_t b, int w0v, int w0, int w1v, int w1);
    flush_i      = (fl != 0);
    es_allowin_i = (al != 0);
    id0_valid_i  = (a.v != 0);    id0_rj_i = 5'(a.rj); id0_rj_re_i = (a.rjre != 0);
    id0_rk_i     = 5'(a.rk);      id0_rk_re_i = (a.rkre != 0);
    id0_rd_i     = 5'(a.rd);      id0_we_i = (a.we != 0);
    id1_valid_i  = (b.v != 0);    id1_rj_i = 5'(b.rj); id1_rj_re_i = (b.rjre != 0);
    id1_rk_i     = 5'(b.rk);      id1_rk_re_i = (b.rkre != 0);
    id1_rd_i     = 5'(b.rd);      id1_we_i = (b.we != 0);
    wb0_valid_i  = (w0v != 0);    wb0_rd_i = 5'(w0);
    wb1_valid_i  = (w1v != 0);    wb1_rd_i = 5'(w1);
  endtask

  function automatic bit pend_m(int r);
    return (r != 0) && (m_cnt[r] != 0);
  endfunction

  function automatic lane_t rnd_lane();
    lane_t l;
    l.v    = ($urandom_range(0, 3) != 0) ? 1 : 0;
    l.rj   = $urandom_range(0, 7);
    l.rjre = $urandom_range(0, 1);
    l.rk   = $urandom_range(0, 7);
    l.rkre = $urandom_range(0, 1);
    l.rd   = $urandom_range(0, 7);
    l.we   = ($urandom_range(0, 3) != 0) ? 1 : 0;
    return l;
  endfunction

  // Retire target: mostly a register that really has a write pending.
  function automatic int pick_wb();
    int cand[$];
    for (int r = 1; r < 8; r++) if (m_cnt[r] > 0) cand.push_back(r);
    if (cand.size() > 0 && $urandom_range(0, 7) != 0)
      return cand[$urandom_range(0, cand.size() - 1)];
    return $urandom_range(0, 7);
  endfunction

  initial begin
    nl = L(0, 0, 0, 0, 0, 0, 0);
    //          fl al lane0                     lane1                    w0v w0 w1v w1  f0 f1 st id er
    tbl[0]  = '{0, 1, L(1, 3, 1, 0, 0, 5, 1),  nl,                      0, 0, 0, 0,  1, 0, 0, 1, 0};
    tbl[1]  = '{0, 1, L(1, 5, 1, 0, 0, 0, 0),  nl,                      0, 0, 0, 0,  0, 0, 1, 0, 0};
    tbl[2]  = '{0, 1, L(1, 5, 1, 0, 0, 0, 0),  nl,                      1, 5, 0, 0,  0, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, L(1, 5, 1, 0, 0, 0, 0),  nl,                      0, 0, 0, 0,  1, 0, 0, 1, 0};
    tbl[4]  = '{0, 1, L(1, 0, 0, 0, 0, 7, 1),  L(1, 0, 0, 7, 1, 0, 0),  0, 0, 0, 0,  1, 0, 0, 1, 0};
    tbl[5]  = '{0, 1, L(1, 0, 0, 7, 1, 0, 0),  nl,                      0, 0, 0, 0,  0, 0, 1, 0, 0};
    tbl[6]  = '{0, 1, L(1, 0, 0, 7, 1, 0, 0),  nl,                      0, 0, 1, 7,  0, 0, 1, 0, 0};
    tbl[7]  = '{0, 1, L(1, 0, 0, 7, 1, 0, 0),  nl,                      0, 0, 0, 0,  1, 0, 0, 1, 0};
    tbl[8]  = '{0, 1, L(1, 0, 1, 0, 0, 0, 1),  L(1, 0, 0, 0, 1, 0, 1),  0, 0, 0, 0,  1, 1, 0, 1, 0};
    tbl[9]  = '{0, 1, nl,                      nl,                      0, 0, 0, 0,  0, 0, 0, 1, 0};
    tbl[10] = '{0, 1, L(1, 0, 0, 0, 0, 9, 1),  nl,                      0, 0, 0, 0,  1, 0, 0, 1, 0};
    tbl[11] = '{0, 1, L(1, 0, 0, 0, 0, 9, 1),  nl,                      0, 0, 0, 0,  1, 0, 0, 0, 0};
    tbl[12] = '{0, 1, L(1, 0, 0, 0, 0, 9, 1),  L(1, 0, 0, 0, 0, 9, 1),  0, 0, 0, 0,  1, 0, 0, 0, 0};
    tbl[13] = '{0, 1, L(1, 0, 0, 0, 0, 9, 1),  nl,                      0, 0, 0, 0,  0, 0, 1, 0, 0};
    tbl[14] = '{0, 0, L(1, 0, 0, 0, 0, 10, 1), nl,                      0, 0, 0, 0,  0, 0, 1, 0, 0};
    tbl[15] = '{0, 1, nl,                      nl,                      1, 9, 1, 9,  0, 0, 0, 0, 0};
    tbl[16] = '{0, 1, L(1, 0, 0, 0, 0, 9, 1),  L(1, 0, 0, 0, 0, 9, 1),  0, 0, 0, 0,  1, 1, 0, 0, 0};
    tbl[17] = '{0, 1, nl,                      nl,                      1, 9, 1, 9,  0, 0, 0, 0, 0};
    tbl[18] = '{0, 1, L(1, 0, 0, 0, 0, 9, 1),  nl,                      1, 9, 0, 0,  1, 0, 0, 0, 0};
    tbl[19] = '{0, 1, L(1, 0, 0, 0, 0, 4, 1),  L(1, 0, 0, 0, 0, 4, 1),  0, 0, 0, 0,  1, 1, 0, 0, 0};
    tbl[20] = '{1, 1, L(1, 0, 0, 0, 0, 11, 1), nl,                      1, 4, 0, 0,  0, 0, 1, 0, 0};
    tbl[21] = '{0, 1, nl,                      nl,                      0, 0, 0, 0,  0, 0, 0, 1, 0};
    tbl[22] = '{0, 1, nl,                      nl,                      1, 4, 0, 0,  0, 0, 0, 1, 0};
    tbl[23] = '{0, 1, nl,                      nl,                      0, 0, 0, 0,  0, 0, 0, 1, 1};
    tbl[24] = '{0, 1, L(1, 0, 0, 0, 0, 6, 1),  nl,                      0, 0, 0, 0,  1, 0, 0, 1, 1};
    tbl[25] = '{0, 1, nl,                      nl,                      0, 0, 0, 0,  0, 0, 0, 0, 1};

    // Reset
    rst = 1'b1;
    drive(0, 0, nl, nl, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_idle", int'(rf_idle_o), 1);
    chk("reset_err", int'(err_o), 0);
    chk("reset_fire0", int'(id0_fire_o), 0);
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < NROW; i++) begin
      drive(tbl[i].fl, tbl[i].al, tbl[i].l0, tbl[i].l1, tbl[i].w0v, tbl[i].w0, tbl[i].w1v, tbl[i].w1);
      @(negedge clk);
      $display("row %0d: fire0=%0d fire1=%0d stall=%0d idle=%0d err=%0d",
               i, id0_fire_o, id1_fire_o, id_stall_o, rf_idle_o, err_o);
      chk($sformatf("row%0d_fire0", i), int'(id0_fire_o), tbl[i].ef0);
      chk($sformatf("row%0d_fire1", i), int'(id1_fire_o), tbl[i].ef1);
      chk($sformatf("row%0d_stall", i), int'(id_stall_o), tbl[i].est);
      chk($sformatf("row%0d_idle", i), int'(rf_idle_o), tbl[i].eidle);
      chk($sformatf("row%0d_err", i), int'(err_o), tbl[i].eerr);
      @(posedge clk); #1;
    end

    // Reset clears the sticky error and the leftover r6 write.
    drive(0, 0, nl, nl, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    $display("post-reset: idle=%0d err=%0d", rf_idle_o, err_o);
    chk("rst2_err", int'(err_o), 0);
    chk("rst2_idle", int'(rf_idle_o), 1);
    @(posedge clk); #1;

    // Randomized run against the model
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 0; m_idle = 1;
    for (int c = 0; c < 400; c++) begin
      lane_t a, b;
      int fl, al, w0v, w0, w1v, w1, waw, n;
      bit hz0, hz1, e0, e1;
      a   = rnd_lane();
      b   = rnd_lane();
      fl  = ($urandom_range(0, 24) == 0) ? 1 : 0;
      al  = ($urandom_range(0, 4) != 0) ? 1 : 0;
      w0v = $urandom_range(0, 1); w0 = pick_wb();
      w1v = $urandom_range(0, 1); w1 = pick_wb();

      hz0 = (a.rjre != 0 && pend_m(a.rj)) || (a.rkre != 0 && pend_m(a.rk)) ||
            (a.we != 0 && a.rd != 0 && m_cnt[a.rd] >= CMAX);
      e0  = (a.v != 0) && (al != 0) && (fl == 0) && !hz0;
      waw = (a.we != 0 && a.rd == b.rd) ? 1 : 0;
      hz1 = (b.rjre != 0 && pend_m(b.rj)) || (b.rkre != 0 && pend_m(b.rk)) ||
            (a.we != 0 && a.rd != 0 &&
             ((b.rjre != 0 && b.rj == a.rd) || (b.rkre != 0 && b.rk == a.rd))) ||
            (b.we != 0 && b.rd != 0 && m_cnt[b.rd] + waw + 1 > CMAX);
      e1  = e0 && (b.v != 0) && !hz1;

      drive(fl, al, a, b, w0v, w0, w1v, w1);
      @(negedge clk);
      $display("rnd %0d: fl=%0d l0v=%0d l1v=%0d fire0=%0d fire1=%0d idle=%0d err=%0d",
               c, fl, a.v, b.v, id0_fire_o, id1_fire_o, rf_idle_o, err_o);
      chk($sformatf("rnd%0d_fire0", c), int'(id0_fire_o), e0 ? 1 : 0);
      chk($sformatf("rnd%0d_fire1", c), int'(id1_fire_o), e1 ? 1 : 0);
      chk($sformatf("rnd%0d_stall", c), int'(id_stall_o), (a.v != 0 && !e0) ? 1 : 0);
      chk($sformatf("rnd%0d_idle", c), int'(rf_idle_o), m_idle);
      chk($sformatf("rnd%0d_err", c), int'(err_o), m_err);

      if (fl != 0) begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      end else begin
        for (int r = 1; r < 32; r++) begin
          n = m_cnt[r]
              + ((e0 && a.we != 0 && a.rd == r) ? 1 : 0)
              + ((e1 && b.we != 0 && b.rd == r) ? 1 : 0)
              - ((w0v != 0 && w0 == r) ? 1 : 0)
              - ((w1v != 0 && w1 == r) ? 1 : 0);
          if (n < 0) begin
            n = 0;
            m_err = 1;
          end
          m_cnt[r] = n;
        end
      end
      m_idle = 1;
      for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) m_idle = 0;
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
